// File: rtl/iot_event_arbiter.sv
// iot_event_arbiter: round-robin arbiter feeding join/leave events from
// N_DEV agents into the shared active-device monitor counter.
module iot_event_arbiter #(
  parameter int N_DEV   = 4,
  parameter int MAX_CNT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DEV-1:0] req,
  input  logic [N_DEV-1:0] dir,
  input  logic             clear,
  output logic [N_DEV-1:0] gnt,
  output logic             rej,
  output logic             mon_rst,
  output logic             mon_on_off,
  output logic             mon_change,
  output logic [7:0]       shadow_cnt,
  output logic             busy
);

  localparam int PW = (N_DEV > 1) ? $clog2(N_DEV) : 1;
  localparam logic [7:0] MAXV = 8'(MAX_CNT);
  localparam logic [PW:0] NV = (PW+1)'(N_DEV);
  localparam logic [PW-1:0] LAST = PW'(N_DEV - 1);

  typedef enum logic [1:0] {
    INIT,
    ARB,
    CLR
  } state_t;

  state_t state, state_n;

  logic [PW-1:0]    rr_ptr, rr_ptr_n;
  logic [N_DEV-1:0] elig;
  logic [N_DEV-1:0] gnt_n;
  logic             rej_n;
  logic             mon_rst_n;
  logic             on_off_n;
  logic             change_n;
  logic [7:0]       cnt_n;
  logic             busy_n;

  logic             found;
  logic [PW-1:0]    win;
  logic [PW:0]      idx;
  logic             win_dir;
  logic             at_max;
  logic             at_zero;
  logic             blocked;

  // An agent still showing req while its grant is high is dropping it.
  assign elig = req & ~gnt;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < N_DEV; k++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(k);
      if (idx >= NV) begin
        idx = idx - NV;
      end
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end

  assign win_dir = dir[win];
  assign at_max  = (shadow_cnt >= MAXV);
  assign at_zero = (shadow_cnt == 8'd0);
  assign blocked = win_dir ? at_max : at_zero;

  always_comb begin
    state_n   = state;
    rr_ptr_n  = rr_ptr;
    gnt_n     = '0;
    rej_n     = 1'b0;
    mon_rst_n = 1'b0;
    on_off_n  = 1'b0;
    change_n  = mon_change;
    cnt_n     = shadow_cnt;
    unique case (state)
      INIT: state_n = ARB;
      CLR:  state_n = ARB;
      ARB: begin
        if (clear) begin
          state_n   = CLR;
          mon_rst_n = 1'b1;
          cnt_n     = 8'd0;
        end else if (found) begin
          gnt_n    = N_DEV'(1) << win;
          rr_ptr_n = (win == LAST) ? '0 : win + PW'(1);
          if (blocked) begin
            rej_n = 1'b1;
          end else begin
            on_off_n = 1'b1;
            change_n = win_dir;
            cnt_n    = win_dir ? shadow_cnt + 8'd1
                               : shadow_cnt - 8'd1;
          end
        end
      end
      default: state_n = INIT;
    endcase
    busy_n = (state_n != ARB) || (|(req & ~gnt_n));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT;
      rr_ptr     <= '0;
      gnt        <= '0;
      rej        <= 1'b0;
      mon_rst    <= 1'b1;
      mon_on_off <= 1'b0;
      mon_change <= 1'b1;
      shadow_cnt <= 8'd0;
      busy       <= 1'b1;
    end else begin
      state      <= state_n;
      rr_ptr     <= rr_ptr_n;
      gnt        <= gnt_n;
      rej        <= rej_n;
      mon_rst    <= mon_rst_n;
      mon_on_off <= on_off_n;
      mon_change <= change_n;
      shadow_cnt <= cnt_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_iot_event_arbiter.sv
// tb_iot_event_arbiter: randomized agents, queue scoreboard against a
// behavioural event model of the arbiter.
module tb_iot_event_arbiter;

  localparam int N   = 4;
  localparam int MAX = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] dir;
  logic         clear;
  logic [N-1:0] gnt;
  logic         rej;
  logic         mon_rst;
  logic         mon_on_off;
  logic         mon_change;
  logic [7:0]   shadow_cnt;
  logic         busy;

  iot_event_arbiter #(
    .N_DEV  (N),
    .MAX_CNT(MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .dir       (dir),
    .clear     (clear),
    .gnt       (gnt),
    .rej       (rej),
    .mon_rst   (mon_rst),
    .mon_on_off(mon_on_off),
    .mon_change(mon_change),
    .shadow_cnt(shadow_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] gnt;
    logic         rej;
    logic         on;
    logic         mrst;
    logic         chg;
    logic [7:0]   cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  int     m_cnt  = 0;
  int     m_ptr  = 0;
  bit     m_hold = 1'b1;
  bit     m_chg  = 1'b1;
  bit [N-1:0] m_gnt = '0;

  // Reference: one decision per edge; after reset or clear one
  // edge passes with no grant, then the lowest pending agent at or
  // after the rotating pointer wins, with the count saturating.
  always @(posedge clk) begin
    exp_t e;
    int   w;
    int   ix;
    e = '{gnt: '0, rej: 1'b0, on: 1'b0, mrst: 1'b0,
          chg: m_chg, cnt: 8'(m_cnt)};
    w = -1;
    if (rst) begin
      m_cnt = 0; m_ptr = 0; m_chg = 1'b1;
      m_hold = 1'b1; m_gnt = '0;
      e.mrst = 1'b1; e.cnt = 8'd0; e.chg = 1'b1;
      exp_q.push_back(e);
    end else if (m_hold) begin
      m_hold = 1'b0; m_gnt = '0;
    end else if (clear) begin
      m_cnt = 0; m_hold = 1'b1; m_gnt = '0;
      e.mrst = 1'b1; e.cnt = 8'd0;
      exp_q.push_back(e);
    end else begin
      for (int k = 0; k < N; k++) begin
        ix = (m_ptr + k) % N;
        if (w < 0 && req[ix] && !m_gnt[ix]) w = ix;
      end
      m_gnt = '0;
      if (w >= 0) begin
        m_gnt[w] = 1'b1;
        m_ptr = (w + 1) % N;
        e.gnt = m_gnt;
        if (dir[w] ? (m_cnt == MAX) : (m_cnt == 0)) begin
          e.rej = 1'b1;
        end else begin
          m_cnt = dir[w] ? m_cnt + 1 : m_cnt - 1;
          m_chg = dir[w];
          e.on = 1'b1;
        end
        e.cnt = 8'(m_cnt);
        e.chg = m_chg;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: every visible event (grant or monitor reset) pops one entry.
  always @(negedge clk) begin
    exp_t e;
    n_chk++;
    if (mon_rst && mon_on_off) begin
      n_fail++;
      $display("FAIL excl: mon_rst=1 with mon_on_off=1 at %0t", $time);
    end
    if (gnt != '0 || mon_rst) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: gnt=%b mon_rst=%b, none expected",
                 gnt, mon_rst);
      end else begin
        e = exp_q.pop_front();
        if (gnt !== e.gnt || rej !== e.rej || mon_on_off !== e.on ||
            mon_rst !== e.mrst || mon_change !== e.chg ||
            shadow_cnt !== e.cnt) begin
          n_fail++;
          $display("FAIL event@%0t: got gnt=%b rej=%b on=%b rst=%b chg=%b cnt=%0d, expected gnt=%b rej=%b on=%b rst=%b chg=%b cnt=%0d",
                   $time, gnt, rej, mon_on_off, mon_rst, mon_change,
                   shadow_cnt, e.gnt, e.rej, e.on, e.mrst, e.chg, e.cnt);
        end
      end
    end
  end

  bit [N-1:0] drop_nxt = '0;

  task automatic chk(input string nm, input int act, input int want);
    n_chk++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, want);
    end
  endtask

  // Agents drop req either right after seeing gnt or one cycle later.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (drop_nxt[i]) begin
        req[i] = 1'b0;
        drop_nxt[i] = 1'b0;
      end else if (req[i] && gnt[i]) begin
        if ($urandom_range(1) == 1) req[i] = 1'b0;
        else drop_nxt[i] = 1'b1;
      end
    end
  endtask

  task automatic post(input int i, input bit d);
    if (!req[i] && !drop_nxt[i] && !gnt[i]) begin
      req[i] = 1'b1;
      dir[i] = d;
    end
  endtask

  task automatic settle();
    repeat (3) step();
  endtask

  initial begin
    int lowest;
    int waited;
    rst = 1'b1; req = '0; dir = '0; clear = 1'b0;

    repeat (3) step();
    chk("rst_busy", int'(busy), 1);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_mon_rst", int'(mon_rst), 1);
    chk("rst_chg", int'(mon_change), 1);
    rst = 1'b0;
    step();
    chk("init_mon_rst", int'(mon_rst), 0);
    chk("init_cnt", int'(shadow_cnt), 0);

    req = 4'b1111; dir = 4'b1111;
    repeat (4) step();
    chk("rr_cnt", int'(shadow_cnt), 4);
    chk("rr_last_gnt", int'(gnt), 8);
    repeat (3) step();
    chk("idle_busy", int'(busy), 0);

    clear = 1'b1; step(); clear = 1'b0; step();
    chk("clr_cnt", int'(shadow_cnt), 0);
    post(2, 1'b0);
    step();
    chk("uf_gnt", int'(gnt), 4);
    chk("uf_rej", int'(rej), 1);
    chk("uf_on", int'(mon_on_off), 0);
    chk("uf_cnt", int'(shadow_cnt), 0);
    settle();

    for (int k = 0; k <= MAX; k++) begin
      post(k % N, 1'b1);
      step();
      if (k == MAX) begin
        chk("of_rej", int'(rej), 1);
        chk("of_cnt", int'(shadow_cnt), MAX);
      end else begin
        chk("join_rej", int'(rej), 0);
      end
      step(); step();
    end

    clear = 1'b1; step(); clear = 1'b0; settle();
    post(1, 1'b1); settle();
    post(2, 1'b1); settle();
    chk("pre_clr_cnt", int'(shadow_cnt), 2);
    clear = 1'b1;
    post(0, 1'b1);
    step();
    clear = 1'b0;
    chk("cvr_mon_rst", int'(mon_rst), 1);
    chk("cvr_gnt", int'(gnt), 0);
    waited = 0;
    while (gnt == '0 && waited < 4) begin
      step();
      waited++;
    end
    chk("cvr_gnt_after", int'(gnt), 1);
    chk("cvr_cnt", int'(shadow_cnt), 1);
    settle();

    req = 4'b1111; dir = 4'b1111;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_gnt", int'(gnt), 0);
    chk("mid_cnt", int'(shadow_cnt), 0);
    chk("mid_mon_rst", int'(mon_rst), 1);
    step();
    lowest = -1;
    for (int i = N - 1; i >= 0; i--) if (req[i]) lowest = i;
    step();
    if (lowest >= 0) chk("mid_first_gnt", int'(gnt), 1 << lowest);
    settle(); settle();

    for (int c = 0; c < 3000; c++) begin
      int pj;
      pj = (c < 1000) ? 75 : (c < 2000) ? 25 : 50;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(99) < 30)
          post(i, $urandom_range(99) < pj);
      end
      clear = ($urandom_range(63) == 0);
      rst = ($urandom_range(399) == 0);
      step();
    end
    clear = 1'b0; rst = 1'b0;
    repeat (3) step();
    req = '0; drop_nxt = '0;
    repeat (10) step();
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
